// File: rtl/frame_arb_pkg.sv
// Shared types and widths for the frame-former ingress arbiter.
package frame_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_XFER  = 2'd2
    } arb_state_t;

    localparam int KEEP_WIDTH = 8;
    localparam int MAC_WIDTH  = 48;
    localparam int SIZE_WIDTH = 14;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin pick: rotate req so last+1 sits at bit 0, take the lowest set bit, rotate the index back.
module rr_priority_picker #(
    parameter int N_SRC = 4,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N_SRC);

    logic [2*N_SRC-1:0] dbl;
    logic [2*N_SRC-1:0] shifted;
    logic [N_SRC-1:0]   rot;
    logic [IDX_W-1:0]   enc;
    logic [IDX_W:0]     sum;

    always_comb begin
        dbl     = {req, req};
        shifted = dbl >> ({1'b0, last} + 1'b1);
        rot     = shifted[N_SRC-1:0];
        any     = |req;
        enc     = '0;
        // Downward scan so the lowest rotated position wins.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rot[IDX_W'(i)]) begin
                enc = IDX_W'(i);
            end
        end
        sum = {1'b0, enc} + {1'b0, last} + 1'b1;
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/frame_source_arbiter.sv
// Packet-atomic round-robin arbiter feeding the frame former's AXI-Stream input,
// latching the granted source's destination/size config one cycle before its first beat.
module frame_source_arbiter
    import frame_arb_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 64,
    localparam int IDX_W     = $clog2(N_SRC)
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [N_SRC*DATA_WIDTH-1:0]  S_AXIS_tdata,
    input  logic [N_SRC*KEEP_WIDTH-1:0]  S_AXIS_tkeep,
    input  logic [N_SRC-1:0]             S_AXIS_tvalid,
    input  logic [N_SRC-1:0]             S_AXIS_tlast,
    output logic [N_SRC-1:0]             S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]        M_AXIS_tdata,
    output logic [KEEP_WIDTH-1:0]        M_AXIS_tkeep,
    output logic                         M_AXIS_tvalid,
    output logic                         M_AXIS_tlast,
    input  logic                         M_AXIS_tready,
    input  logic [N_SRC-1:0]             Src_Enable,
    input  logic [N_SRC*MAC_WIDTH-1:0]   Cfg_Destination,
    input  logic [N_SRC*SIZE_WIDTH-1:0]  Cfg_Packet_Size,
    output logic [MAC_WIDTH-1:0]         Destination_Address,
    output logic [SIZE_WIDTH-1:0]        Packet_Size,
    output logic [IDX_W-1:0]             Grant_Index,
    output logic [1:0]                   Arb_State,
    output logic                         Busy
);

    // AXIS handshake: a beat transfers on a rising edge where tvalid and tready are both high.
    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      last_q;
    logic [MAC_WIDTH-1:0]  dest_q;
    logic [SIZE_WIDTH-1:0] size_q;
    logic                  pick_any;
    logic [IDX_W-1:0]      pick_idx;

    logic [DATA_WIDTH-1:0] src_data [N_SRC];
    logic [KEEP_WIDTH-1:0] src_keep [N_SRC];
    logic [MAC_WIDTH-1:0]  src_dest [N_SRC];
    logic [SIZE_WIDTH-1:0] src_size [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_slice
        assign src_data[g] = S_AXIS_tdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign src_keep[g] = S_AXIS_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH];
        assign src_dest[g] = Cfg_Destination[g*MAC_WIDTH +: MAC_WIDTH];
        assign src_size[g] = Cfg_Packet_Size[g*SIZE_WIDTH +: SIZE_WIDTH];
    end

    rr_priority_picker #(.N_SRC(N_SRC)) u_picker (
        .req  (S_AXIS_tvalid & Src_Enable),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(N_SRC - 1);
            dest_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            // Config is captured only at grant time so mid-packet edits cannot leak in.
            if (state_q == ARB_IDLE && pick_any) begin
                grant_q <= pick_idx;
                last_q  <= pick_idx;
                dest_q  <= src_dest[pick_idx];
                size_q  <= src_size[pick_idx];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        M_AXIS_tdata  = '0;
        M_AXIS_tkeep  = '0;
        M_AXIS_tvalid = 1'b0;
        M_AXIS_tlast  = 1'b0;
        S_AXIS_tready = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                state_d = ARB_XFER;
            end
            ARB_XFER: begin
                M_AXIS_tdata           = src_data[grant_q];
                M_AXIS_tkeep           = src_keep[grant_q];
                M_AXIS_tvalid          = S_AXIS_tvalid[grant_q];
                M_AXIS_tlast           = S_AXIS_tlast[grant_q];
                S_AXIS_tready[grant_q] = M_AXIS_tready;
                if (S_AXIS_tvalid[grant_q] && M_AXIS_tready && S_AXIS_tlast[grant_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign Destination_Address = dest_q;
    assign Packet_Size         = size_q;
    assign Grant_Index         = grant_q;
    assign Arb_State           = state_q;
    assign Busy                = (state_q != ARB_IDLE);

endmodule
